// File: rtl/walk_pkg.sv
// walk_pkg: shared types, defaults and channel-index width helper for the walk request bank
package walk_pkg;
  localparam int N_CH_DEF = 4;
  localparam int WAIT_W_DEF = 8;
  localparam int URGENT_LIMIT_DEF = 200;
  typedef enum logic [1:0] {ST_IDLE, ST_OFFER, ST_SERVE} arb_state_e;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/walk_request_bank_if.sv
// walk_request_bank_if: request/grant bus between the walk request bank (slave) and the light FSM (master)
interface walk_request_bank_if import walk_pkg::*; #(parameter int N_CH = N_CH_DEF);
  localparam int CH_W = ch_w(N_CH);
  logic [N_CH-1:0] wr_sync;
  logic [N_CH-1:0] wr_reset;
  logic [N_CH-1:0] wr;
  logic            grant_valid;
  logic [CH_W-1:0] grant_ch;
  logic            grant_urgent;
  logic            grant_ready;
  modport master (output wr_sync, wr_reset, grant_ready, input wr, grant_valid, grant_ch, grant_urgent);
  modport slave (input wr_sync, wr_reset, grant_ready, output wr, grant_valid, grant_ch, grant_urgent);
endinterface

// File: rtl/walk_rr_arbiter.sv
// walk_rr_arbiter: combinational round-robin pick, first set request after last_i with wrap
module walk_rr_arbiter import walk_pkg::*; #(
  parameter int N_CH = N_CH_DEF,
  parameter int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] last_i,
  output logic            found_o,
  output logic [CH_W-1:0] idx_o
);
  logic [CH_W-1:0] c;
  // scan farthest-first so the nearest candidate after last_i is written last and wins
  always_comb begin
    found_o = 1'b0;
    idx_o = '0;
    c = '0;
    for (int k = N_CH; k >= 1; k--) begin
      c = CH_W'((int'(last_i) + k) % N_CH);
      if (req_i[c]) begin
        found_o = 1'b1;
        idx_o = c;
      end
    end
  end
endmodule

// File: rtl/walk_request_bank.sv
// walk_request_bank: latched walk requests with round-robin grant to the light FSM; WALK_URGENT_EN adds wait-age urgency
module walk_request_bank import walk_pkg::*; #(
  parameter int N_CH = N_CH_DEF,
  parameter int WAIT_W = WAIT_W_DEF,
  parameter int URGENT_LIMIT = URGENT_LIMIT_DEF
) (
  input logic clock,
  input logic reset_sync,
  walk_request_bank_if.slave bus
);
  localparam int CH_W = ch_w(N_CH);
  logic [N_CH-1:0] prev_q, wr_q, wr_d, sel_req;
  arb_state_e state_q, state_d;
  logic [CH_W-1:0] last_q, last_d, ch_q, ch_d, pick;
  logic urg_q, urg_d, found, pick_urg, clr_g;
  assign clr_g = bus.wr_reset[ch_q];
  // buttons held through reset load prev, so they never look like a fresh edge
  always_ff @(posedge clock) prev_q <= bus.wr_sync;
  // a clear beats a same-cycle rising edge; the edge is simply lost
  always_comb wr_d = ~bus.wr_reset & (wr_q | (bus.wr_sync & ~prev_q));
`ifdef WALK_URGENT_EN
  logic [WAIT_W-1:0] wait_q [N_CH];
  logic [N_CH-1:0] urgent;
  // saturating age of each pending request, zeroed while the channel is idle
  always_ff @(posedge clock)
    for (int i = 0; i < N_CH; i++)
      wait_q[i] <= (reset_sync || !wr_q[i]) ? '0 : wait_q[i] + WAIT_W'(~&wait_q[i]);
  // only still-pending channels may count as urgent
  always_comb
    for (int i = 0; i < N_CH; i++)
      urgent[i] = wr_q[i] && (wait_q[i] >= WAIT_W'(URGENT_LIMIT));
  assign sel_req = |urgent ? urgent : wr_q;
  assign pick_urg = |urgent;
`else
  assign sel_req = wr_q;
  assign pick_urg = 1'b0;
`endif
  walk_rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_rr (
    .req_i(sel_req),
    .last_i(last_q),
    .found_o(found),
    .idx_o(pick)
  );
  // offer/serve sequencing; a clear during OFFER withdraws without advancing the rotation
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    urg_d = urg_q;
    last_d = last_q;
    if (state_q == ST_IDLE && found) begin
      state_d = ST_OFFER;
      ch_d = pick;
      urg_d = pick_urg;
    end
    if (state_q == ST_OFFER) state_d = clr_g ? ST_IDLE : bus.grant_ready ? ST_SERVE : ST_OFFER;
    if (state_q == ST_SERVE && clr_g) begin
      state_d = ST_IDLE;
      last_d = ch_q;
    end
  end
  // state registers
  always_ff @(posedge clock) begin
    if (reset_sync) begin
      wr_q <= '0;
      state_q <= ST_IDLE;
      ch_q <= '0;
      urg_q <= 1'b0;
      last_q <= CH_W'(N_CH - 1);
    end else begin
      wr_q <= wr_d;
      state_q <= state_d;
      ch_q <= ch_d;
      urg_q <= urg_d;
      last_q <= last_d;
    end
  end
  assign bus.wr = wr_q;
  assign bus.grant_valid = state_q == ST_OFFER;
  assign bus.grant_ch = ch_q;
  assign bus.grant_urgent = urg_q;
endmodule

// File: tb/tb_walk_request_bank.sv
// tb_walk_request_bank: directed stimulus with a cycle model of the request/grant rules and literal spot checks
module tb_walk_request_bank;
  localparam int N = 4;
  localparam int LIM = 20;
`ifdef WALK_URGENT_EN
  localparam bit URG = 1'b1;
`else
  localparam bit URG = 1'b0;
`endif
  logic clock = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  walk_request_bank_if #(.N_CH(N)) bus();
  walk_request_bank #(.N_CH(N), .WAIT_W(8), .URGENT_LIMIT(LIM)) dut (
    .clock(clock),
    .reset_sync(rst),
    .bus(bus.slave)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  bit [N-1:0] m_wr, m_prev;
  int m_st, m_ch, m_last;
  bit m_urg;
  int age [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // next model state from current inputs: 0 idle, 1 offered, 2 in service
  task automatic model_step();
    bit [N-1:0] urg;
    bit anyu;
    int pick;
    if (rst) begin
      m_wr = '0; m_st = 0; m_ch = 0; m_urg = 0; m_last = N - 1; m_prev = bus.wr_sync;
      for (int i = 0; i < N; i++) age[i] = 0;
      return;
    end
    for (int i = 0; i < N; i++) urg[i] = URG && m_wr[i] && age[i] >= LIM;
    anyu = |urg;
    pick = -1;
    for (int k = N; k >= 1; k--)
      if (anyu ? urg[(m_last + k) % N] : m_wr[(m_last + k) % N]) pick = (m_last + k) % N;
    if (m_st == 0 && pick >= 0) begin m_st = 1; m_ch = pick; m_urg = anyu; end
    else if (m_st == 1) m_st = bus.wr_reset[m_ch] ? 0 : bus.grant_ready ? 2 : 1;
    else if (m_st == 2 && bus.wr_reset[m_ch]) begin m_last = m_ch; m_st = 0; end
    for (int i = 0; i < N; i++) begin
      age[i] = m_wr[i] ? age[i] + 1 : 0;
      if (bus.wr_reset[i]) m_wr[i] = 1'b0;
      else if (bus.wr_sync[i] && !m_prev[i]) m_wr[i] = 1'b1;
    end
    m_prev = bus.wr_sync;
  endtask

  task automatic compare();
    chk("m_wr", bus.wr, m_wr);
    chk("m_valid", bus.grant_valid, m_st == 1);
    if (m_st == 1) begin
      chk("m_ch", bus.grant_ch, m_ch);
      chk("m_urgent", bus.grant_urgent, m_urg);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
    compare();
  endtask

  task automatic serve_one(input int ch, input bit [N-1:0] press, output int n);
    n = 0;
    while (!bus.grant_valid && n < 40) begin cyc(); n++; end
    chk("serve_valid", bus.grant_valid, 1);
    chk("serve_ch", bus.grant_ch, ch);
    bus.grant_ready = 1'b1;
    bus.wr_sync = bus.wr_sync | press;
    cyc();
    bus.grant_ready = 1'b0;
    chk("accept_drop", bus.grant_valid, 0);
    bus.wr_reset = N'(1) << ch;
    cyc();
    bus.wr_reset = '0;
    bus.wr_sync = bus.wr_sync & ~press;
    chk("served_clear", bus.wr[ch], 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_sync = '0;
    bus.wr_reset = '0;
    bus.grant_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bus.wr_sync = '0;
    bus.wr_reset = '0;
    bus.grant_ready = 1'b0;
    do_reset();
    chk("rst_wr", bus.wr, 0);
    chk("rst_valid", bus.grant_valid, 0);
    chk("rst_ch", bus.grant_ch, 0);
    chk("rst_urg", bus.grant_urgent, 0);
    // single press on ch2
    bus.wr_sync = 4'b0100;
    cyc();
    chk("t1_wr", bus.wr, 4'b0100);
    chk("t1_nvalid", bus.grant_valid, 0);
    cyc();
    chk("t1_valid", bus.grant_valid, 1);
    chk("t1_ch", bus.grant_ch, 2);
    bus.grant_ready = 1'b1;
    cyc();
    bus.grant_ready = 1'b0;
    chk("t1_serve", bus.grant_valid, 0);
    bus.wr_reset = 4'b0100;
    cyc();
    bus.wr_reset = '0;
    bus.wr_sync = '0;
    chk("t1_cleared", bus.wr, 0);
    cyc();
    chk("t1_idle", bus.grant_valid, 0);
    // simultaneous presses on 0,1,3 plus re-press of 0 during ch1 service
    do_reset();
    bus.wr_sync = 4'b1011;
    cyc();
    chk("t2_wr", bus.wr, 4'b1011);
    bus.wr_sync = '0;
    serve_one(0, 4'b0000, n);
    serve_one(1, 4'b0001, n);
    chk("t2_gap", n, 1);
    serve_one(3, 4'b0000, n);
    serve_one(0, 4'b0000, n);
    repeat (3) cyc();
    chk("t2_empty", bus.wr, 0);
    // ch1 held across its clear must not re-latch
    bus.wr_sync = 4'b0010;
    cyc();
    chk("t3_set", bus.wr, 4'b0010);
    cyc();
    bus.wr_reset = 4'b0010;
    cyc();
    bus.wr_reset = '0;
    repeat (2) cyc();
    chk("t3_held", bus.wr[1], 0);
    bus.wr_sync = '0;
    cyc();
    bus.wr_sync = 4'b0010;
    cyc();
    chk("t3_repress", bus.wr[1], 1);
    serve_one(1, 4'b0000, n);
    bus.wr_sync = '0;
    cyc();
    // same-cycle edge and clear on ch0
    bus.wr_sync = 4'b0001;
    bus.wr_reset = 4'b0001;
    cyc();
    bus.wr_reset = '0;
    chk("t4_clear_wins", bus.wr[0], 0);
    bus.wr_sync = '0;
    repeat (2) cyc();
    // long-waiting ch3 versus later ch1 after ch0 service
    do_reset();
    bus.wr_sync = 4'b0001;
    cyc();
    bus.wr_sync = '0;
    cyc();
    chk("t5_offer0", bus.grant_ch, 0);
    bus.grant_ready = 1'b1;
    cyc();
    bus.grant_ready = 1'b0;
    bus.wr_sync = 4'b1000;
    cyc();
    bus.wr_sync = '0;
    repeat (25) cyc();
    bus.wr_sync = 4'b0010;
    cyc();
    bus.wr_sync = '0;
    cyc();
    bus.wr_reset = 4'b0001;
    cyc();
    bus.wr_reset = '0;
    cyc();
    chk("t5_valid", bus.grant_valid, 1);
    chk("t5_ch", bus.grant_ch, URG ? 3 : 1);
    chk("t5_urg", bus.grant_urgent, URG);
    serve_one(URG ? 3 : 1, 4'b0000, n);
    serve_one(URG ? 1 : 3, 4'b0000, n);
    // reset during OFFER, then rotation restarts from the last channel
    bus.wr_sync = 4'b0100;
    cyc();
    bus.wr_sync = '0;
    cyc();
    chk("t6_offer", bus.grant_valid, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_valid", bus.grant_valid, 0);
    chk("t6_wr", bus.wr, 0);
    chk("t6_ch", bus.grant_ch, 0);
    bus.wr_sync = 4'b1010;
    cyc();
    bus.wr_sync = '0;
    serve_one(1, 4'b0000, n);
    serve_one(3, 4'b0000, n);
    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/walk_request_bank.md
# walk_request_bank

Parametrised bank of latched pedestrian walk requests, one per crossing, feeding the traffic-light controller FSM. Each channel captures a rising edge of its synchronised button input and holds it until the FSM clears it after serving the walk phase. A round-robin arbiter offers one pending channel at a time to the FSM through a valid/ready handshake. An optional wait-age monitor promotes long-waiting channels to urgent.

## Interface
- N_CH, 4: number of crossings, 1..16
- WAIT_W, 8: width of per-channel wait counter
- URGENT_LIMIT, 200: wait cycles at which a channel becomes urgent; must be < 2^WAIT_W
- clock  in  1  system clock, all logic on rising edge
- reset_sync  in  1  reset, synchronous, active-high
- wr_sync  in  N_CH  synchronised button levels, one per channel
- wr_reset  in  N_CH  per-channel clear from FSM, one-cycle pulse or level
- wr  out  N_CH  latched walk requests
- grant_valid  out  1  a channel is offered to the FSM
- grant_ch  out  CH_W  offered channel index, CH_W = max(1, clog2(N_CH))
- grant_urgent  out  1  offered channel was urgent when selected (0 if macro absent)
- grant_ready  in  1  FSM accepts the offer

## Operation
- Edge capture: register wr_sync into prev; set_i = wr_sync[i] & ~prev[i].
- Per-channel priority, highest first: reset_sync -> 0; wr_reset[i] -> 0; set_i -> 1; else hold. Set and clear in the same cycle: clear wins, edge discarded.
- A button held high across a clear does not re-latch; a new rising edge is required.
- Arbiter states:
  - IDLE: if any wr bit set, select a channel, load grant_ch/grant_urgent, go to OFFER. Otherwise stay.
  - OFFER: grant_valid=1; grant_ch and grant_urgent stable. If grant_ready, go to SERVE. If wr_reset[grant_ch] is asserted first, withdraw and go to IDLE; last_ch is unchanged.
  - SERVE: grant_valid=0. When wr_reset[grant_ch] is asserted, set last_ch=grant_ch and go to IDLE.
- Selection: round-robin, searching from last_ch+1 with wrap to 0. If urgent channels exist (macro present), only urgent channels are searched, in the same rotation order.
- wr_reset on channels other than grant_ch clears only those bits; the state is unaffected.

## Timing
- Reset values:
  - wr=0, grant_valid=0, grant_ch=0, grant_urgent=0
  - state=IDLE, last_ch=N_CH-1
  - all wait counters=0
  - prev loaded with wr_sync, so buttons held through reset do not latch.
- wr_sync first sampled high at edge n: wr[i]=1 after edge n; grant_valid=1 after edge n+1 (when the arbiter is in IDLE).
- Handshake is accepted at the edge where grant_valid & grant_ready; grant_valid drops the following cycle.
- After the clear in SERVE, the next grant_valid rises 2 cycles later if requests remain: IDLE is entered after edge k, and OFFER after edge k+1.
- reset_sync mid-offer or mid-serve: all outputs return to reset values on the next edge.

## Configuration
- WALK_URGENT_EN defined:
  - Per-channel saturating counters of WAIT_W bits count each cycle wr[i]=1, and reset to 0 when wr[i] is 0.
  - urgent[i] = wait[i] >= URGENT_LIMIT.
  - Urgent channels take priority in selection; grant_urgent reflects urgency at the selection cycle.
- WALK_URGENT_EN undefined: no counters are built, grant_urgent is tied to 0, and selection is pure round-robin.

## Structure
- Package walk_pkg:
  - arbiter state enum (IDLE, OFFER, SERVE)
  - CH_W function/constant
  - default parameter constants
- Sub-module walk_rr_arbiter: combinational round-robin pick over a request vector given last_ch; returns a found flag and an index. It is instantiated once, fed by the urgent vector or wr.

## Test plan
- Reset then edge on ch2 -> wr=0100 one cycle later; grant_valid=1, grant_ch=2 the next cycle; grant_ready -> SERVE; wr_reset[2] -> wr=0000, state IDLE.
- Edges on ch0, ch1, ch3 together, with every offer accepted and cleared -> service order 0, 1, 3; a new ch0 press during ch1 service is served after 3.
- ch1 held high through wr_reset[1] -> wr[1] stays 0; release and re-press -> wr[1]=1.
- Set edge and wr_reset on ch0 in the same cycle -> wr[0] stays 0.
- WALK_URGENT_EN, URGENT_LIMIT=20: ch3 pending 20+ cycles while ch0 is in SERVE, and ch1 pressed later -> after ch0 clears, next grant_ch=3 with grant_urgent=1.
- reset_sync asserted during OFFER -> next cycle grant_valid=0, wr=0, last_ch=N_CH-1.
